vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 138 +++++++++++++
 tb/tb_vga_timing.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing
// Raster timing generator for a 640x480 @ 60 Hz display path.
// Divides clk into a one-cycle pixel strobe and steps the horizontal
// (DrawX) and vertical (DrawY) counters. The sync/enable decodes are
// registered from the next counter values, so they always describe the
// pixel currently presented on DrawX/DrawY.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   DrawX        current pixel column, 0..H_TOTAL-1
//   DrawY        current pixel row, 0..V_TOTAL-1
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   vde          video data enable, high in the visible region
//   pixel_en     one-clk strobe, once per pixel period
//   frame_start  one-clk pulse when a new frame begins at (0,0)
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hsync,
  output logic       vsync,
  output logic       vde,
  output logic       pixel_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be in 1..16");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits so an end value of exactly 1024 stays exact.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vde_q, vde_d;
  logic             fs_q, fs_d;
  logic             pix_tick;

  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d   = div_q + 1'b1;
    x_d     = x_q;
    y_d     = y_q;
    fs_d    = 1'b0;
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    vde_d   = 1'b0;

    if (pix_tick) begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          // Registered together with the counters, so it is high exactly
          // in the first cycle that shows (0,0) after the frame wrap.
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decode the values the counters are about to take, so the registered
    // decodes line up with DrawX/DrawY without a pipeline offset.
    hsync_d = !(({1'b0, x_d} >= H_SYNC_BEG) && ({1'b0, x_d} < H_SYNC_END));
    vsync_d = !(({1'b0, y_d} >= V_SYNC_BEG) && ({1'b0, y_d} < V_SYNC_END));
    vde_d   = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      vde_q   <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vde_q   <= vde_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vde         = vde_q;
  // With CLK_DIV=1 the divider compare is always true; gate it so the
  // strobe is low while reset is held.
  assign pixel_en    = pix_tick & ~reset;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (full 640x480 timing, a small
// raster with CLK_DIV=3, and a small raster with CLK_DIV=1). Expected
// outputs come from elapsed clk cycles since reset release.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vde;
    logic       pen;
    logic       fs;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic       rst_f;
  logic [9:0] x_f, y_f;
  logic       hs_f, vs_f, vde_f, pen_f, fs_f;
  // small instance, CLK_DIV=3 (23 x 13 raster)
  logic       rst_s;
  logic [9:0] x_s, y_s;
  logic       hs_s, vs_s, vde_s, pen_s, fs_s;
  // small instance, CLK_DIV=1 (30 x 11 raster)
  logic       rst_1;
  logic [9:0] x_1, y_1;
  logic       hs_1, vs_1, vde_1, pen_1, fs_1;

  vga_timing u_full (
    .clk(clk), .reset(rst_f), .DrawX(x_f), .DrawY(y_f), .hsync(hs_f),
    .vsync(vs_f), .vde(vde_f), .pixel_en(pen_f), .frame_start(fs_f));

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .CLK_DIV(3)
  ) u_small (
    .clk(clk), .reset(rst_s), .DrawX(x_s), .DrawY(y_s), .hsync(hs_s),
    .vsync(vs_s), .vde(vde_s), .pixel_en(pen_s), .frame_start(fs_s));

  vga_timing #(
    .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
  ) u_div1 (
    .clk(clk), .reset(rst_1), .DrawX(x_1), .DrawY(y_1), .hsync(hs_1),
    .vsync(vs_1), .vde(vde_1), .pixel_en(pen_1), .frame_start(fs_1));

  // Expected outputs t clk cycles after reset release (t=0 is the first
  // cycle with reset low).
  function automatic exp_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb,
                                 dv, t);
    exp_t m;
    int ht, vt, pix, ph, x, y;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    pix = t / dv;
    ph  = t % dv;
    x   = pix % ht;
    y   = (pix / ht) % vt;
    m.x   = 10'(x);
    m.y   = 10'(y);
    m.hs  = !(x >= hv + hf && x < hv + hf + hsw);
    m.vs  = !(y >= vv + vf && y < vv + vf + vsw);
    m.vde = (x < hv) && (y < vv);
    m.pen = (ph == dv - 1);
    m.fs  = (pix > 0) && (pix % (ht * vt) == 0) && (ph == 0);
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input int t, input exp_t e,
                     input exp_t a);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0d actual x=%0d y=%0d hs=%b vs=%b vde=%b pen=%b fs=%b required x=%0d y=%0d hs=%b vs=%b vde=%b pen=%b fs=%b",
               name, t, a.x, a.y, a.hs, a.vs, a.vde, a.pen, a.fs,
               e.x, e.y, e.hs, e.vs, e.vde, e.pen, e.fs);
    end
  endtask

  // elapsed-cycle trackers; restart at every edge that samples reset
  int t_f = 0, t_s = 0, t_1 = 0;
  bit v_f = 0, v_s = 0, v_1 = 0;
  int ph_f = 0, ph_s = 0, ph_1 = 0;

  always @(posedge clk) begin
    if (rst_f) begin t_f <= 0; v_f <= 1'b1; end else if (v_f) t_f <= t_f + 1;
    if (rst_s) begin t_s <= 0; v_s <= 1'b1; end else if (v_s) t_s <= t_s + 1;
    if (rst_1) begin t_1 <= 0; v_1 <= 1'b1; end else if (v_1) t_1 <= t_1 + 1;
  end

  int vs_low_cnt = 0, fs_cnt_s = 0, pen_cnt_1 = 0;

  always @(negedge clk) begin
    exp_t e, a;
    if (v_f) begin
      e = model(640, 16, 96, 48, 480, 10, 2, 33, 4, t_f);
      if (rst_f) e.pen = 1'b0;
      a = {x_f, y_f, hs_f, vs_f, vde_f, pen_f, fs_f};
      cmp("full", t_f, e, a);
      if (ph_f == 0 && rst_f) begin
        chk("full_rst_x", int'(x_f), 0);
        chk("full_rst_hs", int'(hs_f), 1);
        chk("full_rst_vde", int'(vde_f), 1);
        chk("full_rst_pen", int'(pen_f), 0);
      end
      if (ph_f == 1) begin
        case (t_f)
          0:    begin chk("full_t0_x", int'(x_f), 0);
                      chk("full_t0_vde", int'(vde_f), 1);
                      chk("full_t0_pen", int'(pen_f), 0); end
          2:    chk("full_t2_pen", int'(pen_f), 0);
          3:    begin chk("full_t3_pen", int'(pen_f), 1);
                      chk("full_t3_x", int'(x_f), 0); end
          4:    chk("full_t4_x", int'(x_f), 1);
          2560: begin chk("full_vde_fall_x", int'(x_f), 640);
                      chk("full_vde_fall", int'(vde_f), 0); end
          2623: begin chk("full_x655", int'(x_f), 655);
                      chk("full_hs_hi655", int'(hs_f), 1); end
          2624: begin chk("full_x656", int'(x_f), 656);
                      chk("full_hs_fall", int'(hs_f), 0); end
          3007: chk("full_hs_lo751", int'(hs_f), 0);
          3008: begin chk("full_x752", int'(x_f), 752);
                      chk("full_hs_rise", int'(hs_f), 1); end
          3199: begin chk("full_x799", int'(x_f), 799);
                      chk("full_y0", int'(y_f), 0); end
          3200: begin chk("full_wrap_x", int'(x_f), 0);
                      chk("full_wrap_y", int'(y_f), 1); end
          default: ;
        endcase
      end
    end

    if (v_s) begin
      e = model(16, 2, 3, 2, 8, 2, 2, 1, 3, t_s);
      if (rst_s) e.pen = 1'b0;
      a = {x_s, y_s, hs_s, vs_s, vde_s, pen_s, fs_s};
      cmp("small", t_s, e, a);
      if (ph_s == 1 && !rst_s) begin
        if (t_s < 897) begin
          if (!vs_s) vs_low_cnt++;
          if (fs_s) fs_cnt_s++;
        end
        if (t_s == 897) begin
          chk("small_vs_low_cycles", vs_low_cnt, 138);
          chk("small_fs_early", fs_cnt_s, 0);
          chk("small_fs_at_frame", int'(fs_s), 1);
          chk("small_fs_x", int'(x_s), 0);
          chk("small_fs_y", int'(y_s), 0);
        end
        if (t_s == 898) chk("small_fs_width", int'(fs_s), 0);
        if (t_s == 1713) begin
          chk("small_pre_rst_x", int'(x_s), 19);
          chk("small_pre_rst_y", int'(y_s), 11);
          chk("small_pre_rst_hs", int'(hs_s), 0);
          chk("small_pre_rst_vs", int'(vs_s), 0);
        end
      end
      if (ph_s == 2 && !rst_s && t_s == 0) begin
        chk("small_post_rst_xy", int'({x_s, y_s}), 0);
        chk("small_post_rst_sync", int'({hs_s, vs_s, vde_s}), 7);
        chk("small_post_rst_fs", int'(fs_s), 0);
      end
    end

    if (v_1) begin
      e = model(20, 3, 4, 3, 6, 1, 2, 2, 1, t_1);
      if (rst_1) e.pen = 1'b0;
      a = {x_1, y_1, hs_1, vs_1, vde_1, pen_1, fs_1};
      cmp("div1", t_1, e, a);
      if (ph_1 == 1 && !rst_1) begin
        if (t_1 < 330 && pen_1) pen_cnt_1++;
        case (t_1)
          0:   chk("div1_t0_pen", int'(pen_1), 1);
          1:   chk("div1_t1_x", int'(x_1), 1);
          29:  chk("div1_t29_x", int'(x_1), 29);
          30:  chk("div1_line_xy", int'({x_1, y_1}), 1);
          329: chk("div1_t329_fs", int'(fs_1), 0);
          330: begin chk("div1_frame_fs", int'(fs_1), 1);
                     chk("div1_frame_xy", int'({x_1, y_1}), 0);
                     chk("div1_pen_cnt", pen_cnt_1, 330); end
          331: chk("div1_fs_width", int'(fs_1), 0);
          default: ;
        endcase
      end
    end
  end

  task automatic random_resets(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 299) == 0) begin
        if (sel == 0) rst_s = 1'b1; else rst_1 = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        if (sel == 0) rst_s = 1'b0; else rst_1 = 1'b0;
      end
    end
  endtask

  initial begin
    rst_f = 1'b1;
    rst_s = 1'b1;
    rst_1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_f = 1'b0;
    rst_s = 1'b0;
    rst_1 = 1'b0;
    ph_f = 1;
    ph_s = 1;
    ph_1 = 1;
    fork
      begin
        repeat (3300) @(posedge clk);
      end
      begin
        // second frame, (19,11): inside both hsync and vsync
        repeat (1714) @(posedge clk);
        #1 rst_s = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_s = 1'b0;
        ph_s = 2;
        repeat (1000) @(posedge clk);
        #1 ph_s = 3;
        random_resets(0, 2500);
      end
      begin
        repeat (700) @(posedge clk);
        #1 ph_1 = 2;
        random_resets(1, 2500);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
